// File: rtl/spart_pkg.sv
// ----------------------------------------------------------------------------
// spart_pkg
// Shared definitions for the SPART bus-master driver:
//   state_t        - controller states
//   ADDR_*         - SPART register addresses driven on ioaddr
//   DIVISOR_TABLE  - 13-bit baud divisors for a 50 MHz clock, indexed by br_cfg
//   dbh_byte()     - formats the high divisor byte for the DBH register
// ----------------------------------------------------------------------------
package spart_pkg;

    typedef enum logic [2:0] {
        CFG_LO = 3'd0,
        CFG_HI = 3'd1,
        ARB    = 3'd2,
        RD_RX  = 3'd3,
        WR_TX  = 3'd4
    } state_t;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    // Element 0 is the rightmost entry: 00=19200, 01=38400, 10=57600, 11=115200.
    localparam logic [3:0][12:0] DIVISOR_TABLE = {
        13'h01B2,
        13'h0364,
        13'h0516,
        13'h0A2C
    };

    function automatic logic [7:0] dbh_byte(input logic [12:0] div);
        return {3'b000, div[12:8]};
    endfunction

endpackage

// File: rtl/spart_driver_tx_arb.sv
// ----------------------------------------------------------------------------
// spart_driver_tx_arb
// Two-requester round-robin grant for the SPART TX queue.
//   clk, rst      - clock and synchronous active-high reset
//   i_req_echo    - echo buffer holds a byte to send
//   i_req_host    - host has a byte to send
//   i_update      - a write is being launched with the current grant
//   o_grant_echo  - echo path wins this arbitration
//   o_grant_host  - host path wins this arbitration
// r_last_host = 1 means the host won the last contested grant, so the echo
// path wins the next tie.
// ----------------------------------------------------------------------------
module spart_driver_tx_arb #(
    parameter bit LAST_HOST_INIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req_echo,
    input  logic i_req_host,
    input  logic i_update,
    output logic o_grant_echo,
    output logic o_grant_host
);

    logic r_last_host;

    always_comb begin
        o_grant_echo = i_req_echo && (!i_req_host || r_last_host);
        o_grant_host = i_req_host && (!i_req_echo || !r_last_host);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_host <= LAST_HOST_INIT;
        end else if (i_update) begin
            r_last_host <= o_grant_host;
        end
    end

endmodule

// File: rtl/spart_driver.sv
// ----------------------------------------------------------------------------
// spart_driver
// Bus master that sequences the SPART register interface.
//   clk, rst           - clock, synchronous active-high reset
//   br_cfg             - baud select; divisor is (re)programmed when it changes
//   echo_en            - copy every received byte into the echo buffer
//   host_tx_valid/data - host transmit request; host_tx_ready acknowledges
//   host_rx_valid/data - one-cycle pulse with each received byte (data held)
//   cfg_done           - divisor programmed for the current br_cfg
//   iocs_n, iorw_n,
//   ioaddr, databus    - SPART register bus; databus driven only on writes
//   tx_q_full          - SPART TX queue full
//   rx_q_empty         - SPART RX queue empty
// The state register names the bus access currently on the bus: the access
// is launched by the edge that enters the state and closed by the edge that
// leaves it. Every access returns to ARB, which keeps the bus idle, so two
// accesses are never adjacent and the SPART flags settle before a decision.
// ----------------------------------------------------------------------------
module spart_driver
    import spart_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter bit          ECHO_DEFAULT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       echo_en,
    input  logic       host_tx_valid,
    input  logic [7:0] host_tx_data,
    output logic       host_tx_ready,
    output logic       host_rx_valid,
    output logic [7:0] host_rx_data,
    output logic       cfg_done,
    output logic       iocs_n,
    output logic       iorw_n,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       tx_q_full,
    input  logic       rx_q_empty
);

    // The divisor table is only valid for the nominal 50 MHz clock.
    if (CLK_HZ != 50000000) begin : g_nonstandard_clk
    end

    state_t     r_state;
    logic [1:0] r_cfg;
    logic       r_iocs_n;
    logic       r_iorw_n;
    logic [1:0] r_ioaddr;
    logic [7:0] r_dout;
    logic       r_cfg_done;
    logic       r_rx_valid;
    logic [7:0] r_rx_data;
    logic       r_echo_valid;
    logic [7:0] r_echo_data;
    logic       r_host_ack;

    logic w_grant_echo;
    logic w_grant_host;
    logic w_cfg_change;
    logic w_rx_go;
    logic w_tx_go;
    logic w_arb_update;

    assign w_cfg_change = (br_cfg != r_cfg);
    // A valid echo byte blocks further reads: this is the RX backpressure.
    assign w_rx_go      = !rx_q_empty && !r_echo_valid;
    assign w_tx_go      = (r_echo_valid || host_tx_valid) && !tx_q_full;
    assign w_arb_update = (r_state == ARB) && !w_cfg_change && !w_rx_go && w_tx_go;

    spart_driver_tx_arb #(
        .LAST_HOST_INIT (ECHO_DEFAULT)
    ) u_tx_arb (
        .clk          (clk),
        .rst          (rst),
        .i_req_echo   (r_echo_valid),
        .i_req_host   (host_tx_valid),
        .i_update     (w_arb_update),
        .o_grant_echo (w_grant_echo),
        .o_grant_host (w_grant_host)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= CFG_LO;
            r_cfg        <= 2'b00;
            r_iocs_n     <= 1'b1;
            r_iorw_n     <= 1'b1;
            r_ioaddr     <= ADDR_BUF;
            r_dout       <= 8'h00;
            r_cfg_done   <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_rx_data    <= 8'h00;
            r_echo_valid <= 1'b0;
            r_echo_data  <= 8'h00;
            r_host_ack   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_host_ack <= 1'b0;
            case (r_state)
                CFG_LO: begin
                    if (r_iocs_n) begin
                        // Straight out of reset nothing is on the bus yet:
                        // latch the selection and launch the DBL write now.
                        r_cfg    <= br_cfg;
                        r_iocs_n <= 1'b0;
                        r_iorw_n <= 1'b0;
                        r_ioaddr <= ADDR_DBL;
                        r_dout   <= DIVISOR_TABLE[br_cfg][7:0];
                    end else begin
                        r_ioaddr <= ADDR_DBH;
                        r_dout   <= dbh_byte(DIVISOR_TABLE[r_cfg]);
                        r_state  <= CFG_HI;
                    end
                end
                CFG_HI: begin
                    r_iocs_n   <= 1'b1;
                    r_iorw_n   <= 1'b1;
                    r_ioaddr   <= ADDR_BUF;
                    r_cfg_done <= 1'b1;
                    r_state    <= ARB;
                end
                ARB: begin
                    if (w_cfg_change) begin
                        r_cfg_done <= 1'b0;
                        r_cfg      <= br_cfg;
                        r_iocs_n   <= 1'b0;
                        r_iorw_n   <= 1'b0;
                        r_ioaddr   <= ADDR_DBL;
                        r_dout     <= DIVISOR_TABLE[br_cfg][7:0];
                        r_state    <= CFG_LO;
                    end else if (w_rx_go) begin
                        r_iocs_n <= 1'b0;
                        r_iorw_n <= 1'b1;
                        r_ioaddr <= ADDR_BUF;
                        r_state  <= RD_RX;
                    end else if (w_tx_go) begin
                        r_iocs_n   <= 1'b0;
                        r_iorw_n   <= 1'b0;
                        r_ioaddr   <= ADDR_BUF;
                        r_dout     <= w_grant_echo ? r_echo_data : host_tx_data;
                        r_host_ack <= w_grant_host;
                        if (w_grant_echo) begin
                            r_echo_valid <= 1'b0;
                        end
                        r_state    <= WR_TX;
                    end
                end
                RD_RX: begin
                    r_rx_data  <= databus;
                    r_rx_valid <= 1'b1;
                    if (echo_en) begin
                        r_echo_data  <= databus;
                        r_echo_valid <= 1'b1;
                    end
                    r_iocs_n <= 1'b1;
                    r_iorw_n <= 1'b1;
                    r_ioaddr <= ADDR_BUF;
                    r_state  <= ARB;
                end
                WR_TX: begin
                    r_iocs_n <= 1'b1;
                    r_iorw_n <= 1'b1;
                    r_ioaddr <= ADDR_BUF;
                    r_state  <= ARB;
                end
                default: begin
                    r_iocs_n <= 1'b1;
                    r_iorw_n <= 1'b1;
                    r_ioaddr <= ADDR_BUF;
                    r_state  <= CFG_LO;
                end
            endcase
        end
    end

    assign iocs_n        = r_iocs_n;
    assign iorw_n        = r_iorw_n;
    assign ioaddr        = r_ioaddr;
    assign cfg_done      = r_cfg_done;
    assign host_rx_valid = r_rx_valid;
    assign host_rx_data  = r_rx_data;
    // A write cycle cut short by reset must not count as a host transfer.
    assign host_tx_ready = r_host_ack && !rst;
    assign databus       = (!r_iocs_n && !r_iorw_n) ? r_dout : 8'hzz;

endmodule

// File: tb/tb_spart_driver.sv
module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       echo_en;
    logic       host_tx_valid;
    logic [7:0] host_tx_data;
    logic       host_tx_ready;
    logic       host_rx_valid;
    logic [7:0] host_rx_data;
    logic       cfg_done;
    logic       iocs_n;
    logic       iorw_n;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       tx_q_full;
    logic       rx_q_empty;
    logic [7:0] tb_rxb;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    // SPART model side: returns tb_rxb whenever the driver performs a read.
    assign databus = (!iocs_n && iorw_n) ? tb_rxb : 8'hzz;

    spart_driver #(
        .CLK_HZ       (50000000),
        .ECHO_DEFAULT (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .br_cfg        (br_cfg),
        .echo_en       (echo_en),
        .host_tx_valid (host_tx_valid),
        .host_tx_data  (host_tx_data),
        .host_tx_ready (host_tx_ready),
        .host_rx_valid (host_rx_valid),
        .host_rx_data  (host_rx_data),
        .cfg_done      (cfg_done),
        .iocs_n        (iocs_n),
        .iorw_n        (iorw_n),
        .ioaddr        (ioaddr),
        .databus       (databus),
        .tx_q_full     (tx_q_full),
        .rx_q_empty    (rx_q_empty)
    );

    typedef struct {
        int         reps;
        // expected outputs for the cycle
        logic       cs_n;
        logic       rw_n;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic       done;
        logic       rdy;
        logic       rxv;
        logic [7:0] rxd;
        // inputs applied after the check, sampled at the next edge
        logic [1:0] cfg;
        logic       echo;
        logic       htv;
        logic [7:0] htd;
        logic       full;
        logic       empty;
        logic [7:0] rxb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int reps,
                                input logic cs_n, input logic rw_n, input logic [1:0] addr,
                                input logic [7:0] wdata, input logic done, input logic rdy,
                                input logic rxv, input logic [7:0] rxd,
                                input logic [1:0] cfg, input logic echo, input logic htv,
                                input logic [7:0] htd, input logic full, input logic empty,
                                input logic [7:0] rxb);
        vec_t v;
        v.reps = reps; v.cs_n = cs_n; v.rw_n = rw_n; v.addr = addr; v.wdata = wdata;
        v.done = done; v.rdy = rdy; v.rxv = rxv; v.rxd = rxd;
        v.cfg = cfg; v.echo = echo; v.htv = htv; v.htd = htd;
        v.full = full; v.empty = empty; v.rxb = rxb;
        return v;
    endfunction

    // {cs_n, rw_n, addr, write data (0 unless a write), cfg_done, ready, rx_valid, rx_data}
    function automatic logic [22:0] pack_exp(input vec_t v);
        logic [7:0] wd;
        wd = (!v.cs_n && !v.rw_n) ? v.wdata : 8'h00;
        return {v.cs_n, v.rw_n, v.addr, wd, v.done, v.rdy, v.rxv, v.rxd};
    endfunction

    function automatic logic [22:0] pack_act();
        logic [7:0] wd;
        wd = (!iocs_n && !iorw_n) ? databus : 8'h00;
        return {iocs_n, iorw_n, ioaddr, wd, cfg_done, host_tx_ready, host_rx_valid, host_rx_data};
    endfunction

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got cs_n/rw_n/addr/wd/done/rdy/rxv/rxd=%b/%b/%h/%h/%b/%b/%b/%h required %b/%b/%h/%h/%b/%b/%b/%h",
                     name, act[22], act[21], act[20:19], act[18:11], act[10], act[9], act[8], act[7:0],
                     exp[22], exp[21], exp[20:19], exp[18:11], exp[10], exp[9], exp[8], exp[7:0]);
        end else begin
            $display("ok   %s: cs_n=%b rw_n=%b addr=%h wd=%h done=%b rdy=%b rxv=%b rxd=%h",
                     name, act[22], act[21], act[20:19], act[18:11], act[10], act[9], act[8], act[7:0]);
        end
    endtask

    task automatic apply(input vec_t v);
        br_cfg        = v.cfg;
        echo_en       = v.echo;
        host_tx_valid = v.htv;
        host_tx_data  = v.htd;
        tx_q_full     = v.full;
        rx_q_empty    = v.empty;
        tb_rxb        = v.rxb;
    endtask

    initial begin
        vec_t rv;
        // -------- stimulus table (idle bus = cs_n 1, rw_n 1, addr 0) --------
        //              reps cs rw ad wd     dn rd rv rxd     cfg ec hv htd    fu em rxb
        vecs.push_back(mk(1, 0,0,2,8'hB2, 0,0,0,8'h00, 3,1,0,8'h00, 0,1,8'h00)); // DBL 115200
        vecs.push_back(mk(1, 0,0,3,8'h01, 0,0,0,8'h00, 3,1,0,8'h00, 0,1,8'h00)); // DBH
        vecs.push_back(mk(1, 1,1,0,8'h00, 1,0,0,8'h00, 3,1,0,8'h00, 0,1,8'h00)); // idle, done
        vecs.push_back(mk(1, 1,1,0,8'h00, 1,0,0,8'h00, 0,1,0,8'h00, 0,1,8'h00)); // cfg -> 19200
        vecs.push_back(mk(1, 0,0,2,8'h2C, 0,0,0,8'h00, 0,1,0,8'h00, 0,1,8'h00));
        vecs.push_back(mk(1, 0,0,3,8'h0A, 0,0,0,8'h00, 0,1,0,8'h00, 0,1,8'h00));
        vecs.push_back(mk(1, 1,1,0,8'h00, 1,0,0,8'h00, 0,1,0,8'h00, 0,1,8'h00));
        vecs.push_back(mk(1, 1,1,0,8'h00, 1,0,0,8'h00, 0,1,0,8'h00, 0,0,8'h41)); // RX 41 ready
        vecs.push_back(mk(1, 0,1,0,8'h00, 1,0,0,8'h00, 0,1,0,8'h00, 0,1,8'h41)); // read
        vecs.push_back(mk(1, 1,1,0,8'h00, 1,0,1,8'h41, 0,1,0,8'h00, 0,1,8'h41)); // rx pulse
        vecs.push_back(mk(1, 0,0,0,8'h41, 1,0,0,8'h41, 0,1,0,8'h00, 0,1,8'h41)); // echo write
        vecs.push_back(mk(1, 1,1,0,8'h00, 1,0,0,8'h41, 0,1,1,8'h55, 0,1,8'h41)); // host 55
        vecs.push_back(mk(1, 0,0,0,8'h55, 1,1,0,8'h41, 0,1,0,8'h55, 0,1,8'h41)); // host wins
        vecs.push_back(mk(1, 1,1,0,8'h00, 1,0,0,8'h41, 0,1,1,8'h55, 0,0,8'h41)); // RX + host
        vecs.push_back(mk(1, 0,1,0,8'h00, 1,0,0,8'h41, 0,1,1,8'h55, 0,1,8'h41)); // RX first
        vecs.push_back(mk(1, 1,1,0,8'h00, 1,0,1,8'h41, 0,1,1,8'h55, 0,1,8'h41));
        vecs.push_back(mk(1, 0,0,0,8'h41, 1,0,0,8'h41, 0,1,1,8'h55, 0,1,8'h41)); // tie: echo
        vecs.push_back(mk(1, 1,1,0,8'h00, 1,0,0,8'h41, 0,1,1,8'h55, 0,1,8'h41));
        vecs.push_back(mk(1, 0,0,0,8'h55, 1,1,0,8'h41, 0,1,0,8'h55, 0,1,8'h41)); // then host
        vecs.push_back(mk(1, 1,1,0,8'h00, 1,0,0,8'h41, 0,1,0,8'h55, 1,0,8'h7E)); // full, RX 7E
        vecs.push_back(mk(1, 0,1,0,8'h00, 1,0,0,8'h41, 0,1,0,8'h55, 1,0,8'h7E)); // read anyway
        vecs.push_back(mk(1, 1,1,0,8'h00, 1,0,1,8'h7E, 0,1,1,8'hA5, 1,0,8'h7E));
        vecs.push_back(mk(20,1,1,0,8'h00, 1,0,0,8'h7E, 0,1,1,8'hA5, 1,0,8'h7E)); // stalled
        vecs.push_back(mk(1, 1,1,0,8'h00, 1,0,0,8'h7E, 0,1,1,8'hA5, 0,0,8'hC3)); // full drops
        vecs.push_back(mk(1, 0,0,0,8'h7E, 1,0,0,8'h7E, 0,1,1,8'hA5, 0,0,8'hC3)); // echo 7E
        vecs.push_back(mk(1, 1,1,0,8'h00, 1,0,0,8'h7E, 0,1,1,8'hA5, 0,0,8'hC3));
        vecs.push_back(mk(1, 0,1,0,8'h00, 1,0,0,8'h7E, 0,1,1,8'hA5, 0,1,8'hC3)); // RX resumes
        vecs.push_back(mk(1, 1,1,0,8'h00, 1,0,1,8'hC3, 0,0,1,8'hA5, 0,1,8'hC3)); // echo_en off
        vecs.push_back(mk(1, 0,0,0,8'hA5, 1,1,0,8'hC3, 0,0,0,8'hA5, 0,1,8'hC3)); // tie: host
        vecs.push_back(mk(1, 1,1,0,8'h00, 1,0,0,8'hC3, 0,0,0,8'hA5, 0,1,8'hC3));
        vecs.push_back(mk(1, 0,0,0,8'hC3, 1,0,0,8'hC3, 0,0,0,8'hA5, 0,0,8'h99)); // pending echo
        vecs.push_back(mk(1, 1,1,0,8'h00, 1,0,0,8'hC3, 0,0,0,8'hA5, 0,0,8'h99));
        vecs.push_back(mk(1, 0,1,0,8'h00, 1,0,0,8'hC3, 0,0,0,8'hA5, 0,1,8'h99));
        vecs.push_back(mk(1, 1,1,0,8'h00, 1,0,1,8'h99, 0,0,0,8'hA5, 0,1,8'h99));
        vecs.push_back(mk(1, 1,1,0,8'h00, 1,0,0,8'h99, 0,0,0,8'hA5, 0,1,8'h99)); // no echo
        vecs.push_back(mk(1, 1,1,0,8'h00, 1,0,0,8'h99, 0,0,1,8'h3C, 0,1,8'h99));

        // -------- reset state --------
        rst = 1'b1;
        apply(mk(1, 1,1,0,8'h00, 0,0,0,8'h00, 3,1,0,8'h00, 0,1,8'h00));
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", pack_act(),
              pack_exp(mk(1, 1,1,0,8'h00, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,8'h00)));
        rst = 1'b0;

        // -------- table-driven run --------
        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                @(posedge clk);
                #1;
                check($sformatf("row%0d.%0d", i, r), pack_act(), pack_exp(vecs[i]));
                apply(vecs[i]);
            end
        end

        // -------- reset during a host write cycle --------
        @(posedge clk);
        #1;
        check("host_write_3C", pack_act(),
              pack_exp(mk(1, 0,0,0,8'h3C, 1,1,0,8'h99, 0,0,0,8'h00, 0,0,8'h00)));
        rst = 1'b1;
        #1;
        n_checks++;
        if (host_tx_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_no_ack: host_tx_ready=%b required 0", host_tx_ready);
        end else begin
            $display("ok   rst_no_ack: host_tx_ready=0 while reset is asserted");
        end
        @(posedge clk);
        #1;
        check("rst_abort", pack_act(),
              pack_exp(mk(1, 1,1,0,8'h00, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,8'h00)));
        rst = 1'b0;
        @(posedge clk);
        #1;
        rv = mk(1, 0,0,2,8'h2C, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,8'h00);
        check("restart_cfg_lo", pack_act(), pack_exp(rv));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
